// File: rtl/gf_serial_reducer_if.sv
`default_nettype none
// ============================================================================
// Module      : gf_serial_reducer_if
// Description : Valid/ready input and output channels of gf_serial_reducer.
// Revision    : 1.0 - initial release
// ============================================================================
interface gf_serial_reducer_if #(
    parameter int DATA_WIDTH = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [2*DATA_WIDTH-1:0]   prod;
    logic [DATA_WIDTH:0]       polyn;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out;
    logic                      err;

    modport master (
        output in_valid, prod, polyn, out_ready,
        input  in_ready, out_valid, out, err
    );

    modport slave (
        input  in_valid, prod, polyn, out_ready,
        output in_ready, out_valid, out, err
    );
endinterface
`default_nettype wire

// File: rtl/gf_serial_reducer.sv
`default_nettype none
// ============================================================================
// Module      : gf_serial_reducer
// Description : Bit-serial GF(2^m) reduction of a 2m-bit carry-less product
//               modulo a programmable polynomial, one exponent per clock.
//               Optional macro GF_RED_EARLY_EXIT_EN: leave REDUCE as soon as
//               the upper half of the remainder is already zero.
// Revision    : 1.0 - initial release
// ============================================================================
module gf_serial_reducer #(
    parameter int DATA_WIDTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    gf_serial_reducer_if.slave     red_if
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int KW = $clog2(PW);
    localparam logic [KW-1:0] K_TOP  = KW'(PW - 1);
    localparam logic [KW-1:0] K_LAST = KW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [PW-1:0]           rem_q;
    logic [DATA_WIDTH:0]     poly_q;
    logic [KW-1:0]           k_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_q;
    logic                    err_q;

    logic [PW-1:0]           poly_ext;
    logic [PW-1:0]           poly_aligned;
    logic [PW-1:0]           rem_d;

    // Bits above k are already cleared, so aligning poly's top bit with k
    // and XORing the whole word equals XORing rem[k:k-W] with poly.
    always_comb begin
        poly_ext     = PW'(poly_q);
        poly_aligned = poly_ext << (k_q - K_LAST);
        rem_d        = rem_q;
        if (rem_q[k_q]) begin
            rem_d = rem_q ^ poly_aligned;
        end
    end

`ifdef GF_RED_EARLY_EXIT_EN
    logic high_zero;
    assign high_zero = (rem_q[PW-1:DATA_WIDTH] == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            poly_q      <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (red_if.in_valid && in_ready_q) begin
                        rem_q      <= red_if.prod;
                        poly_q     <= red_if.polyn;
                        k_q        <= K_TOP;
                        err_q      <= ~red_if.polyn[DATA_WIDTH];
                        in_ready_q <= 1'b0;
                        state_q    <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    // A bad polynomial spends one pass-through cycle here so the
                    // error result appears one edge after accept.
                    if (err_q) begin
                        out_q       <= rem_q[DATA_WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
`ifdef GF_RED_EARLY_EXIT_EN
                    else if (high_zero) begin
                        out_q       <= rem_q[DATA_WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
`endif
                    else begin
                        rem_q <= rem_d;
                        k_q   <= k_q - 1'b1;
                        if (k_q == K_LAST) begin
                            out_q       <= rem_d[DATA_WIDTH-1:0];
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (red_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign red_if.in_ready  = in_ready_q;
    assign red_if.out_valid = out_valid_q;
    assign red_if.out       = out_q;
    assign red_if.err       = err_q;

endmodule
`default_nettype wire
